// File: rtl/data_ram_pkg.sv
// data_ram_pkg: transfer size encodings, responder states and byte-lane helpers
package data_ram_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    function automatic logic [7:0] lane_mask(input size_t size, input logic [2:0] offset);
        logic [8:0] m;
        m = (9'd1 << (4'd1 << size)) - 9'd1;
        return 8'(m << offset);
    endfunction

    function automatic logic [63:0] byte_expand(input logic [7:0] be);
        for (int i = 0; i < 8; i++) byte_expand[8*i +: 8] = {8{be[i]}};
    endfunction
endpackage

// File: rtl/data_ram_array.sv
// data_ram_array: 2^ADDR_W x 64-bit synchronous RAM, byte write enables, one read and one write port
module data_ram_array #(
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] widx,
    input  logic [7:0]        wbe,
    input  logic [63:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] ridx,
    output logic [63:0]       rdata
);
    logic [63:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) if (we && wbe[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[ridx];
    end
endmodule

// File: rtl/data_ram_slave.sv
// data_ram_slave: data-port bus responder over an on-chip RAM with wait states and write-to-read forwarding.
// DATA_RAM_ERR_RESP_EN enables range/alignment error responses; otherwise addresses wrap and misalignment is cleared.
module data_ram_slave
    import data_ram_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HTRANS,
    input  logic        HWRITE,
    input  logic [63:0] HADDR,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              p_write;
    size_t             p_size;
    logic [2:0]        p_off;
    logic [ADDR_W-1:0] p_idx;
    logic              f_en;
    logic [63:0]       f_mask, f_data;
    logic [63:0]       rel, ram_q, merged, wdata;
    logic [ADDR_W-1:0] a_idx;
    size_t             a_size;
    logic [2:0]        a_align, a_off;
    logic              a_err, accept, commit, re;
    logic [7:0]        wbe;

    assign rel     = HADDR - BASE_ADDR;
    assign a_idx   = ADDR_W'(rel >> 3);
    assign a_size  = HSIZE > 3'd3 ? SZ_D : size_t'(HSIZE[1:0]);
    assign a_align = 3'((4'd1 << a_size) - 4'd1);
`ifdef DATA_RAM_ERR_RESP_EN
    assign a_err = HADDR < BASE_ADDR || (rel >> (ADDR_W + 3)) != 64'd0 || (HADDR[2:0] & a_align) != 3'd0;
    assign a_off = HADDR[2:0];
`else
    assign a_err = 1'b0;
    assign a_off = HADDR[2:0] & ~a_align;
`endif
    assign accept = HTRANS && HREADY;
    assign commit = state == DATA && cnt == 4'd0 && p_write;
    assign re     = accept && !HWRITE && !a_err;
    assign wbe    = lane_mask(p_size, p_off);
    assign wdata  = HWDATA << {p_off, 3'b000};
    // The RAM read on a committing edge returns the old word; patch in the bytes just written.
    assign merged = f_en ? (ram_q & ~f_mask | f_data & f_mask) : ram_q;

    data_ram_array #(.ADDR_W(ADDR_W)) u_array (
        .CLK   (CLK),
        .we    (commit),
        .widx  (p_idx),
        .wbe   (wbe),
        .wdata (wdata),
        .re    (re),
        .ridx  (a_idx),
        .rdata (ram_q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == ERR1 ? ERR2 : !HREADY ? state : !accept ? IDLE : a_err ? ERR1 : DATA;
    end

    always_comb begin
        HREADY = state == IDLE || state == ERR2 || (state == DATA && cnt == 4'd0);
`ifdef DATA_RAM_ERR_RESP_EN
        HRESP  = state == ERR1 || state == ERR2;
`else
        HRESP  = 1'b0;
`endif
        HRDATA = state == DATA && !p_write ? merged >> {p_off, 3'b000} : 64'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= 4'd0;
            p_write <= 1'b0;
            p_size  <= SZ_B;
            p_off   <= 3'd0;
            p_idx   <= '0;
            f_en    <= 1'b0;
            f_mask  <= 64'd0;
            f_data  <= 64'd0;
        end else if (accept) begin
            cnt     <= 4'(WAIT_CYCLES);
            p_write <= HWRITE;
            p_size  <= a_size;
            p_off   <= a_off;
            p_idx   <= a_idx;
            f_en    <= commit && p_idx == a_idx;
            f_mask  <= byte_expand(wbe);
            f_data  <= wdata;
        end else if (state == DATA && cnt != 4'd0) begin
            cnt     <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_data_ram_slave.sv
// tb_data_ram_slave: scoreboard bench for data_ram_slave with zero-wait and three-wait instances;
// error-response vectors are included when DATA_RAM_ERR_RESP_EN is defined.
module tb_data_ram_slave;
    typedef struct {
        int          id;
        bit          rd;
        logic [63:0] data;
        bit          resp;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        htrans [2];
    logic        hwrite [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [63:0] haddr  [2];
    logic [63:0] hwdata [2];
    logic [63:0] hrdata [2];
    logic [2:0]  hsize  [2];

    exp_t q[$];
    bit [1:0] in_ph;
    int wc [2];
    int n_cmp = 0, n_bad = 0, next_id = 0;

    always #5 clk = ~clk;

    data_ram_slave #(.WAIT_CYCLES(0)) u0 (
        .CLK(clk), .RST_N(rst_n), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HADDR(haddr[0]),
        .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0])
    );

    data_ram_slave #(.WAIT_CYCLES(3)) u3 (
        .CLK(clk), .RST_N(rst_n), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HADDR(haddr[1]),
        .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1])
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Monitor: tracks each instance's data phase from the bus and checks every completion against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_ph = '0;
            wc    = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_ph[i]) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL dut%0d_unexpected_phase: got activity want none", i);
                        in_ph[i] = 1'b0;
                    end else if (!hready[i]) begin
                        wc[i]++;
                        chk($sformatf("x%0d_resp_wait", q[0].id), 64'(hresp[i]), 64'(q[0].resp));
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("x%0d_resp", e.id), 64'(hresp[i]), 64'(e.resp));
                        chk($sformatf("x%0d_waits", e.id), 64'(wc[i]), 64'(e.waits));
                        if (e.rd && !e.resp) chk($sformatf("x%0d_rdata", e.id), hrdata[i], e.data);
                        in_ph[i] = 1'b0;
                        wc[i]    = 0;
                    end
                end
                if (htrans[i] && hready[i]) in_ph[i] = 1'b1;
            end
        end
    end

    task automatic xfer(input int d, input bit w, input logic [63:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, input logic [63:0] ed, input bit er);
        exp_t e;
        int t;
        e.id    = next_id++;
        e.rd    = !w;
        e.data  = ed;
        e.resp  = er;
        e.waits = er ? 1 : (d == 1 ? 3 : 0);
        q.push_back(e);
        htrans[d] = 1'b1;
        hwrite[d] = w;
        haddr[d]  = a;
        hsize[d]  = sz;
        t = 0;
        @(negedge clk);
        while (!hready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!hready[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL x%0d_accept: got no HREADY want acceptance within 50 cycles", e.id);
        end
        @(posedge clk);
        #1;
        htrans[d] = 1'b0;
        hwdata[d] = wd;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || in_ph != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0 || in_ph != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            htrans[d] = 1'b0;
            hwrite[d] = 1'b0;
            haddr[d]  = 64'd0;
            hsize[d]  = 3'd3;
            hwdata[d] = 64'd0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_hready%0d", d), 64'(hready[d]), 64'd1);
            chk($sformatf("reset_hresp%0d", d), 64'(hresp[d]), 64'd0);
            chk($sformatf("reset_hrdata%0d", d), hrdata[d], 64'd0);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 1, 64'h8000_0010, 3'd3, 64'h1122_3344_5566_7788, 64'd0, 0);
        xfer(0, 0, 64'h8000_0013, 3'd0, 64'd0, 64'h0000_0011_2233_4455, 0);
        xfer(0, 0, 64'h8000_0016, 3'd1, 64'd0, 64'h0000_0000_0000_1122, 0);
        xfer(0, 1, 64'h8000_0011, 3'd0, 64'h0000_0000_0000_00AA, 64'd0, 0);
        xfer(0, 0, 64'h8000_0010, 3'd3, 64'd0, 64'h1122_3344_5566_AA88, 0);
        xfer(0, 1, 64'h8000_0014, 3'd2, 64'h0000_0000_DEAD_BEEF, 64'd0, 0);
        xfer(0, 0, 64'h8000_0014, 3'd2, 64'd0, 64'h0000_0000_DEAD_BEEF, 0);
        xfer(0, 1, 64'h8000_0012, 3'd1, 64'hFFFF_FFFF_FFFF_1234, 64'd0, 0);
        xfer(0, 0, 64'h8000_0010, 3'd3, 64'd0, 64'hDEAD_BEEF_1234_AA88, 0);
`ifdef DATA_RAM_ERR_RESP_EN
        xfer(0, 1, 64'h8000_0002, 3'd2, 64'h0000_0000_CAFE_BABE, 64'd0, 1);
        xfer(0, 1, 64'h8000_0012, 3'd2, 64'h0000_0000_CAFE_BABE, 64'd0, 1);
        xfer(0, 0, 64'h7FFF_FFF8, 3'd3, 64'd0, 64'd0, 1);
        xfer(0, 0, 64'h8000_8000, 3'd3, 64'd0, 64'd0, 1);
        xfer(0, 0, 64'h8000_0010, 3'd3, 64'd0, 64'hDEAD_BEEF_1234_AA88, 0);
`else
        xfer(0, 0, 64'h8000_8010, 3'd3, 64'd0, 64'hDEAD_BEEF_1234_AA88, 0);
        xfer(0, 0, 64'h8000_0013, 3'd1, 64'd0, 64'h0000_DEAD_BEEF_1234, 0);
        xfer(0, 1, 64'h8000_8015, 3'd2, 64'h0000_0000_0BAD_F00D, 64'd0, 0);
        xfer(0, 0, 64'h8000_0010, 3'd3, 64'd0, 64'h0BAD_F00D_1234_AA88, 0);
`endif
        drain();

        xfer(1, 1, 64'h8000_0020, 3'd3, 64'h0102_0304_0506_0708, 64'd0, 0);
        xfer(1, 0, 64'h8000_0020, 3'd3, 64'd0, 64'h0102_0304_0506_0708, 0);
        xfer(1, 0, 64'h8000_0024, 3'd2, 64'd0, 64'h0000_0000_0102_0304, 0);
`ifdef DATA_RAM_ERR_RESP_EN
        xfer(1, 0, 64'h7FFF_FFF8, 3'd3, 64'd0, 64'd0, 1);
`endif
        drain();

        // Abort a write in its first wait cycle; the word must keep its old contents.
        xfer(1, 1, 64'h8000_0020, 3'd3, 64'hFFEE_DDCC_BBAA_9988, 64'd0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_hready", 64'(hready[1]), 64'd1);
        chk("midreset_hresp", 64'(hresp[1]), 64'd0);
        chk("midreset_hrdata", hrdata[1], 64'd0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 0, 64'h8000_0020, 3'd3, 64'd0, 64'h0102_0304_0506_0708, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_ram_slave.md
# data_ram_slave

Bus responder for the memory-access stage's data port: accepts the single-bit-HTRANS, 64-bit address/data transfers the load/store stage issues and serves them from an on-chip byte-addressable RAM. It sits on the far side of HADDR/HWDATA/HWRITE/HTRANS/HRDATA from the memory-access stage. It adds HREADY wait states, an optional error response, byte-lane steering, and write-to-read forwarding. Read data is right-justified, so the initiator's sign/zero extension of HRDATA[7:0]/[15:0]/[31:0] is always correct.

## Interface
- ADDR_W, 12, doubleword index bits (RAM = 2^ADDR_W x 64 bit)
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of RAM word 0
- WAIT_CYCLES, 0, HREADY-low cycles inserted per data phase (0..15)

- CLK  in  1  clock; all state on posedge
- RST_N  in  1  reset; asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- HTRANS  in  1  1 = valid transfer in address phase
- HWRITE  in  1  1 = write, 0 = read
- HADDR  in  64  byte address
- HSIZE  in  3  0=byte,1=half,2=word,3=dword; initiators without size drive 3
- HWDATA  in  64  write data, right-justified, valid in data phase
- HRDATA  out  64  read data, right-justified, valid when HREADY=1 in data phase
- HREADY  out  1  1 = data phase completes this cycle / new address phase accepted
- HRESP  out  1  1 = error response

## Operation
- Address phase accepted on posedge when HTRANS=1 and HREADY=1. Capture HWRITE, HSIZE, HADDR[2:0], word index, and error check into phase registers.
- States: IDLE, DATA, ERR1, ERR2.
- IDLE: accepted OK transfer -> DATA. Accepted erroring transfer -> ERR1. Otherwise stay.
- DATA: wait counter loaded with WAIT_CYCLES at acceptance; HREADY=0 while counter≠0, decrement per cycle. When counter=0, HREADY=1 and the phase completes. The next state follows the same acceptance rules as IDLE (back-to-back transfers allowed), else IDLE.
- ERR1: HREADY=0, HRESP=1 -> ERR2. ERR2: HREADY=1, HRESP=1; next state per acceptance rules. Erroring writes modify nothing.
- Write: on completing edge, byte mask = ((1<<2^HSIZE)-1) << HADDR[2:0], data = HWDATA << 8*HADDR[2:0]. Only masked bytes are written.
- Read: RAM read of captured index, output = word >> 8*HADDR[2:0]. Upper bytes beyond size are don't-care, but driven as the shifted word (no masking).
- Forwarding: a read accepted on the same edge a write to the same word completes must return the merged (new-byte) data.
- Error: HADDR outside [BASE_ADDR, BASE_ADDR + 8·2^ADDR_W), or HADDR not aligned to 2^HSIZE.

## Timing
- Reset values: HRDATA=0, HREADY=1, HRESP=0, state IDLE, counter 0. RAM contents are not reset.
- WAIT_CYCLES=0: address accepted at edge N; HRDATA valid and HREADY=1 throughout cycle N→N+1; write committed at edge N+1.
- Each wait cycle delays completion by exactly one clock; throughput is 1 transfer per (WAIT_CYCLES+1) cycles.
- Error: exactly 2 cycles (ERR1, ERR2) regardless of WAIT_CYCLES.
- HTRANS while HREADY=0 is ignored (not queued).
- RST_N low mid-phase: pending write discarded, outputs return to reset values immediately.

## Configuration
- DATA_RAM_ERR_RESP_EN defined: range/alignment checking and the ERR1/ERR2 response as above.
- Undefined: HRESP tied 0 and no ERR states. The index wraps modulo 2^ADDR_W (BASE_ADDR subtracted, high bits dropped). Misaligned addresses have their low bits cleared to the size alignment before steering.

## Structure
- Package data_ram_pkg: HSIZE encodings, state enum, function lane_mask(size, offset) returning 8-bit byte enable.
- Sub-module data_ram_array: 2^ADDR_W x 64 synchronous RAM with 8-bit byte write enable, one read and one write port; forwarding mux stays in data_ram_slave.

## Test plan
- Reset: RST_N low -> HREADY=1, HRESP=0, HRDATA=0.
- Write SD 64'h1122_3344_5566_7788 @0x8000_0010, then LB @0x8000_0013 -> HRDATA[7:0]=8'h55. LHU @0x8000_0016 -> HRDATA[15:0]=16'h1122.
- SB 8'hAA @0x8000_0011 immediately followed by LD @0x8000_0010 -> 64'h1122_3344_5566_AA88 (forwarded).
- WAIT_CYCLES=3: read -> HREADY low 3 cycles, data on 4th; next address accepted only on that cycle.
- With DATA_RAM_ERR_RESP_EN: SW @0x8000_0002 -> HRESP=1 for 2 cycles, HREADY 0 then 1, RAM unchanged. Read @0x7FFF_FFF8 -> same error response.
- RST_N pulsed during a write's wait cycle -> subsequent read of that word returns the old value.
